lcd_16207_sequencer: RTL

// Avalon-MM slave that queues HD44780/16207 character-LCD commands and data in a FIFO.
// A timing FSM replays each entry onto the LCD bus with correct setup, E-pulse and hold

---
 rtl/lcd_16207_sequencer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/lcd_16207_sequencer.sv
// lcd_16207_sequencer: Avalon-MM slave that queues HD44780/16207 LCD
// cmd/data bytes and replays them with bus timing and busy-flag polling.
// Ports: clk, reset_n (sync, low); address/read/write/writedata/readdata
// Avalon slave (0=cmd, 1=data, 2=status, 3=control); LCD_E/RS/RW outputs,
// LCD_data bidirectional bus (driven while LCD_RW=0).
module lcd_16207_sequencer #(
  parameter int FIFO_DEPTH   = 8,
  parameter int T_SETUP      = 3,
  parameter int T_EPW        = 25,
  parameter int T_HOLD       = 2,
  parameter int T_REC        = 25,
  parameter int BUSY_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int T1 = (T_SETUP > T_EPW) ? T_SETUP : T_EPW;
  localparam int T2 = (T_HOLD > T_REC) ? T_HOLD : T_REC;
  localparam int TMAX = (T1 > T2) ? T1 : T2;
  localparam int PW = $clog2(TMAX + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_SETUP,
    S_W_PULSE,
    S_W_HOLD,
    S_W_REC,
    S_P_SETUP,
    S_P_PULSE,
    S_P_HOLD,
    S_P_REC
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ph;
  logic [TW-1:0]   r_to;
  logic            r_bf;
  logic            r_tmo;
  logic            r_ovf;
  logic [7:0]      r_data;
  logic [8:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_push_ok;
  logic w_ovf_set;
  logic w_ctl;
  logic w_clr_ovf;
  logic w_clr_tmo;
  logic w_last;
  logic w_poll;
  logic w_busy;
  logic w_drv;
  logic [3:0] w_cnt4;

  assign w_push    = write & ~address[1];
  assign w_pop     = (r_state == S_IDLE) & (r_count != '0);
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  // a pop in the same cycle frees the slot the push needs
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;
  assign w_ctl     = write & (address == 2'd3);
  assign w_clr_ovf = w_ctl & writedata[0];
  assign w_clr_tmo = w_ctl & writedata[1];
  assign w_last    = (r_ph == '0);
  assign w_poll    = (r_state == S_P_SETUP) | (r_state == S_P_PULSE) |
                     (r_state == S_P_HOLD)  | (r_state == S_P_REC);
  assign w_busy    = (r_state != S_IDLE) | (r_count != '0);
  assign w_cnt4    = 4'(r_count);
  assign w_drv     = ~LCD_RW;

  assign LCD_data = w_drv ? r_data : 8'hzz;

  always_comb begin
    readdata = 8'h00;
    if (read && address == 2'd2)
      readdata = {r_ovf, r_tmo, w_busy, 1'b0, w_cnt4};
  end

  always_ff @(posedge clk) begin
    if (w_push_ok)
      r_mem[r_wptr] <= {address[0], writedata};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (w_clr_ovf)
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ph    <= '0;
      r_to    <= '0;
      r_bf    <= 1'b0;
      r_tmo   <= 1'b0;
      r_data  <= 8'h00;
      LCD_E   <= 1'b0;
      LCD_RS  <= 1'b0;
      LCD_RW  <= 1'b0;
    end else begin
      // clear first so a timeout set below in this cycle wins
      if (w_clr_tmo)
        r_tmo <= 1'b0;
      if (!w_last)
        r_ph <= r_ph - PW'(1);
      if (w_poll && r_to < TW'(BUSY_TIMEOUT))
        r_to <= r_to + TW'(1);
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {LCD_RS, r_data} <= r_mem[r_rptr];
            LCD_RW  <= 1'b0;
            r_ph    <= PW'(T_SETUP - 1);
            r_state <= S_W_SETUP;
          end
        end
        S_W_SETUP: begin
          if (w_last) begin
            LCD_E   <= 1'b1;
            r_ph    <= PW'(T_EPW - 1);
            r_state <= S_W_PULSE;
          end
        end
        S_W_PULSE: begin
          if (w_last) begin
            LCD_E   <= 1'b0;
            r_ph    <= PW'(T_HOLD - 1);
            r_state <= S_W_HOLD;
          end
        end
        S_W_HOLD: begin
          if (w_last) begin
            r_ph    <= PW'(T_REC - 1);
            r_state <= S_W_REC;
          end
        end
        S_W_REC: begin
          if (w_last) begin
            LCD_RS  <= 1'b0;
            LCD_RW  <= 1'b1;
            r_to    <= '0;
            r_ph    <= PW'(T_SETUP - 1);
            r_state <= S_P_SETUP;
          end
        end
        S_P_SETUP: begin
          if (w_last) begin
            LCD_E   <= 1'b1;
            r_ph    <= PW'(T_EPW - 1);
            r_state <= S_P_PULSE;
          end
        end
        S_P_PULSE: begin
          if (w_last) begin
            r_bf    <= LCD_data[7];
            LCD_E   <= 1'b0;
            r_ph    <= PW'(T_HOLD - 1);
            r_state <= S_P_HOLD;
          end
        end
        S_P_HOLD: begin
          if (w_last) begin
            r_ph    <= PW'(T_REC - 1);
            r_state <= S_P_REC;
          end
        end
        S_P_REC: begin
          if (w_last) begin
            if (!r_bf) begin
              LCD_RW  <= 1'b0;
              r_state <= S_IDLE;
            end else if (r_to < TW'(BUSY_TIMEOUT)) begin
              r_ph    <= PW'(T_SETUP - 1);
              r_state <= S_P_SETUP;
            end else begin
              r_tmo   <= 1'b1;
              LCD_RW  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
